// File: rtl/block_pkg.sv
// Shared definitions for the brick-breaker game controller.
// Holds the top-level state codes and the default game constants.
package block_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_LOST  = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } state_t;

  localparam int unsigned DEF_LIVES        = 3;
  localparam int unsigned DEF_BRICKS       = 32;
  localparam int unsigned DEF_SCORE_W      = 10;
  localparam int unsigned DEF_SERVE_FRAMES = 60;
  localparam int unsigned DEF_DEB_FRAMES   = 3;

  // Paddle may only move while the ball is being served or in play.
  function automatic logic is_move_state(state_t s);
    return (s == ST_SERVE) || (s == ST_PLAY);
  endfunction

endpackage

// File: rtl/block_game_ctrl_if.sv
// Control/event link between the game sequencer and block_main.
//   brick_hit, ball_lost : one-cycle event pulses from block_main
//   run                  : physics update enable
//   serve_load           : hold ball on paddle / reload position
//   move_left/move_right : paddle direction
// master = sequencer side, slave = block_main side.
interface block_game_ctrl_if;
  logic brick_hit;
  logic ball_lost;
  logic run;
  logic serve_load;
  logic move_left;
  logic move_right;

  modport master (
    input  brick_hit, ball_lost,
    output run, serve_load, move_left, move_right
  );

  modport slave (
    output brick_hit, ball_lost,
    input  run, serve_load, move_left, move_right
  );
endinterface

// File: rtl/key_debounce.sv
// Single-key debouncer, frame-paced.
//   CLOCK_50    : clock
//   reset       : asynchronous active-low reset
//   frame_tick  : one-cycle pulse per video frame (sampling strobe)
//   key_raw     : raw active-low button
//   pressed     : debounced level, 1 = pressed
//   press_pulse : one-clock pulse on debounced released->pressed edge
module key_debounce #(
  parameter int unsigned DEB_FRAMES = 3
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic frame_tick,
  input  logic key_raw,
  output logic pressed,
  output logic press_pulse
);

  localparam int unsigned CW = $clog2(DEB_FRAMES + 1);

  logic          sync1, sync2;
  logic          level;    // debounced, raw polarity (1 = released)
  logic          level_d;
  logic [CW-1:0] run_cnt;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      level       <= 1'b1;
      level_d     <= 1'b1;
      run_cnt     <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= key_raw;
      sync2       <= sync1;
      level_d     <= level;
      press_pulse <= level_d & ~level;
      if (frame_tick) begin
        if (sync2 == level) begin
          run_cnt <= '0;
        end else if (run_cnt == CW'(DEB_FRAMES - 1)) begin
          level   <= sync2;
          run_cnt <= '0;
        end else begin
          run_cnt <= run_cnt + 1'b1;
        end
      end
    end
  end

  assign pressed = ~level;

endmodule

// File: rtl/block_game_ctrl.sv
// Brick-breaker game sequencer.
//   CLOCK_50    : clock
//   reset       : asynchronous active-low reset
//   frame_tick  : one-cycle pulse per video frame
//   KEY[2:0]    : raw active-low keys, [0] start/serve, [1] right, [2] left
//   bus         : events in / run, serve_load, paddle direction out
//   state       : current state code
//   lives       : remaining lives
//   score       : saturating points counter
//   bricks_left : bricks remaining in the level
module block_game_ctrl
  import block_pkg::*;
#(
  parameter int unsigned LIVES        = DEF_LIVES,
  parameter int unsigned BRICKS       = DEF_BRICKS,
  parameter int unsigned SCORE_W      = DEF_SCORE_W,
  parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int unsigned DEB_FRAMES   = DEF_DEB_FRAMES
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic [2:0]                    KEY,
  block_game_ctrl_if.master             bus,
  output logic [2:0]                    state,
  output logic [1:0]                    lives,
  output logic [SCORE_W-1:0]            score,
  output logic [$clog2(BRICKS+1)-1:0]   bricks_left
);

  localparam int unsigned BW = $clog2(BRICKS + 1);
  localparam int unsigned TW = $clog2(SERVE_FRAMES + 1);

  state_t        state_q, state_nx;
  logic [TW-1:0] serve_cnt;
  logic [2:0]    key_level;
  logic [2:0]    key_press;
  logic          start_press;
  logic          last_brick;
  logic          run_nx, serve_load_nx, move_left_nx, move_right_nx;
  logic          unused_keys;

  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debounce #(
      .DEB_FRAMES(DEB_FRAMES)
    ) u_deb (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .key_raw     (KEY[i]),
      .pressed     (key_level[i]),
      .press_pulse (key_press[i])
    );
  end

  assign start_press = key_press[0];
  assign unused_keys = ^{key_level[0], key_press[2:1]};
  assign last_brick  = bus.brick_hit && (bricks_left == BW'(1));

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE:  if (start_press) state_nx = ST_SERVE;
      ST_SERVE: if (start_press || (frame_tick && serve_cnt <= TW'(1))) state_nx = ST_PLAY;
      ST_PLAY: begin
        // A simultaneous loss on the last brick is overridden by the win.
        if (last_brick)         state_nx = ST_WIN;
        else if (bus.ball_lost) state_nx = ST_LOST;
      end
      ST_LOST:  if (frame_tick) state_nx = (lives == 2'd0) ? ST_OVER : ST_SERVE;
      ST_OVER,
      ST_WIN:   if (start_press) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up with state.
    run_nx        = (state_nx == ST_PLAY);
    serve_load_nx = (state_nx == ST_IDLE) || (state_nx == ST_SERVE);
    move_left_nx  = is_move_state(state_nx) &&  key_level[2] && !key_level[1];
    move_right_nx = is_move_state(state_nx) &&  key_level[1] && !key_level[2];
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      bus.run        <= 1'b0;
      bus.serve_load <= 1'b1;
      bus.move_left  <= 1'b0;
      bus.move_right <= 1'b0;
      lives          <= 2'(LIVES);
      score          <= '0;
      bricks_left    <= BW'(BRICKS);
      serve_cnt      <= '0;
    end else begin
      state_q        <= state_nx;
      bus.run        <= run_nx;
      bus.serve_load <= serve_load_nx;
      bus.move_left  <= move_left_nx;
      bus.move_right <= move_right_nx;

      // Reload on the way into IDLE so the new values appear with the state change.
      if (state_nx == ST_IDLE) begin
        lives       <= 2'(LIVES);
        score       <= '0;
        bricks_left <= BW'(BRICKS);
      end else if (state_q == ST_PLAY) begin
        if (bus.brick_hit) begin
          if (score != '1)       score       <= score + 1'b1;
          if (bricks_left != '0) bricks_left <= bricks_left - 1'b1;
        end
        if (bus.ball_lost && !last_brick && lives != 2'd0)
          lives <= lives - 1'b1;
      end

      if (state_nx == ST_SERVE && state_q != ST_SERVE)
        serve_cnt <= TW'(SERVE_FRAMES);
      else if (state_q == ST_SERVE && frame_tick && serve_cnt != '0)
        serve_cnt <= serve_cnt - 1'b1;
    end
  end

  assign state = state_q;

endmodule
